packed_array_wr_arbiter: RTL

//   Round-robin write arbiter and owner of a packed 3-D register bank

---
 rtl/packed_array_wr_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/packed_array_wr_arbiter.sv
// Round-robin write arbiter that owns a packed PLANES x ROWS x W register bank.
// Exports the whole bank plus a registered single-element read port.
module packed_array_wr_arbiter #(
  parameter int NREQ   = 4,
  parameter int PLANES = 2,
  parameter int ROWS   = 3,
  parameter int W      = 4,
  parameter logic [PLANES*ROWS*W-1:0] INIT = 24'h6E5_6E5,
  localparam int PW  = (PLANES > 1) ? $clog2(PLANES) : 1,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               lock,
  input  logic [NREQ-1:0]                    req_valid,
  output logic [NREQ-1:0]                    req_ready,
  input  logic [NREQ-1:0][PW-1:0]            req_plane,
  input  logic [NREQ-1:0][RW-1:0]            req_row,
  input  logic [NREQ-1:0][W-1:0]             req_data,
  output logic [PLANES-1:0][ROWS-1:0][W-1:0] mem,
  output logic                               wr_done,
  output logic [IDW-1:0]                     wr_id,
  output logic                               err_oob,
  input  logic [PW-1:0]                      rd_plane,
  input  logic [RW-1:0]                      rd_row,
  output logic [W-1:0]                       rd_data
);

  // Handshake: a request transfers in any cycle where req_valid[i] && req_ready[i];
  // a requester holds valid/plane/row/data stable until it sees ready, and ready
  // is derived only from valid, lock and rr_ptr (never from the payload).
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] next_ptr;
  logic           accept;
  logic [PW-1:0]  sel_plane;
  logic [RW-1:0]  sel_row;
  logic [W-1:0]   sel_data;
  logic           in_range;
  logic           rd_in_range;

  // Scan upward from rr_ptr with wrap; the first valid requester wins.
  // Grants are forced low while reset is asserted so nothing is offered mid-reset.
  always_comb begin
    int idx;
    idx       = 0;
    accept    = 1'b0;
    grant_id  = '0;
    req_ready = '0;
    if (rst_n && !lock) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = (int'(rr_ptr) + k) % NREQ;
        if (!accept && req_valid[idx]) begin
          accept   = 1'b1;
          grant_id = IDW'(idx);
        end
      end
    end
    req_ready[grant_id] = accept;
  end

  assign sel_plane   = req_plane[grant_id];
  assign sel_row     = req_row[grant_id];
  assign sel_data    = req_data[grant_id];
  assign in_range    = (int'(sel_plane) < PLANES) && (int'(sel_row) < ROWS);
  assign rd_in_range = (int'(rd_plane) < PLANES) && (int'(rd_row) < ROWS);
  assign next_ptr    = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem     <= INIT;
      rr_ptr  <= '0;
      wr_done <= 1'b0;
      err_oob <= 1'b0;
      wr_id   <= '0;
      rd_data <= '0;
    end else begin
      wr_done <= accept && in_range;
      err_oob <= accept && !in_range;
      if (accept) begin
        rr_ptr <= next_ptr;
      end
      if (accept && in_range) begin
        mem[sel_plane][sel_row] <= sel_data;
        wr_id                   <= grant_id;
      end
      // Reads see the bank before this cycle's commit.
      rd_data <= rd_in_range ? mem[rd_plane][rd_row] : '0;
    end
  end

endmodule
